// File: rtl/bp_pkg.sv
// Shared types and index helpers for the gshare/BTB predictor.
// Struct fields use fixed maximum widths; the top slices them.
package bp_pkg;

  localparam int TAG_MAX = 32;
  localparam int GHR_MAX = 32;

  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_INIT = 2'b01;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [63:0]        target;
    logic               is_cond;
  } btb_entry_t;

  typedef struct packed {
    logic [GHR_MAX-1:0] idx_ghr;
    logic [GHR_MAX-1:0] hist;
  } ckpt_t;

  function automatic logic [31:0] lo_mask(input int bits);
    if (bits >= 32) return '1;
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic logic [31:0] pht_idx(
    input logic [63:0] pc,
    input logic [31:0] ghr,
    input int          bits
  );
    return (pc[33:2] ^ ghr) & lo_mask(bits);
  endfunction

  function automatic logic [31:0] btb_idx(
    input logic [63:0] pc,
    input int          bits
  );
    return pc[33:2] & lo_mask(bits);
  endfunction

  function automatic logic [31:0] btb_tag(
    input logic [63:0] pc,
    input int          idx_bits,
    input int          tag_bits
  );
    logic [63:0] s;
    s = pc >> (idx_bits + 2);
    return s[31:0] & lo_mask(tag_bits);
  endfunction

  function automatic ctr_t ctr_next(input ctr_t c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bp_ckpt_queue.sv
// Circular GHR checkpoint buffer: up to LANES allocs per cycle,
// one pop from the head, and a full clear on redirect.
module bp_ckpt_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LANES = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [CW-1:0]        alloc_n_in,
  input  ckpt_t [LANES-1:0]    alloc_data_in,
  input  logic                 pop_in,
  input  logic                 clear_in,
  output ckpt_t                head_out,
  output logic [PW-1:0]        tail_out,
  output logic [CW-1:0]        count_out
);

  ckpt_t         mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input int            k
  );
    return PW'((int'(p) + k) % DEPTH);
  endfunction

  assign head_out  = mem[head];
  assign tail_out  = tail;
  assign count_out = count;

  // Store the compacted allocations at consecutive tail slots.
  always_ff @(posedge clk_in) begin
    if (!rst_in && !clear_in) begin
      for (int k = 0; k < LANES; k++) begin
        if (k < int'(alloc_n_in))
          mem[wrap(tail, k)] <= alloc_data_in[k];
      end
    end
  end

  // Pointer and occupancy bookkeeping; alloc and pop may coincide.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop_in) head <= wrap(head, 1);
      tail  <= wrap(tail, int'(alloc_n_in));
      count <= count + alloc_n_in - CW'(pop_in);
    end
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Multi-lane gshare direction + tagged BTB target predictor with a
// speculative GHR checkpointed per predicted conditional branch.
module gshare_btb_predictor
  import bp_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int GHR_BITS     = 8,
  parameter int PHT_IDX_BITS = 10,
  parameter int BTB_ENTRIES  = 128,
  parameter int TAG_BITS     = 12,
  parameter int CKPT_DEPTH   = 8,
  localparam int IDW = $clog2(CKPT_DEPTH),
  localparam int CW  = $clog2(CKPT_DEPTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req_valid_in,
  input  logic [63:0]           req_pc_in,
  output logic                  req_ready_out,
  output logic                  resp_valid_out,
  output logic [LANES-1:0]      resp_lane_valid,
  output logic [LANES-1:0]      resp_taken,
  output logic [64*LANES-1:0]   resp_target,
  output logic [63:0]           resp_next_pc,
  output logic [IDW*LANES-1:0]  resp_ckpt_id,
  input  logic                  upd_valid_in,
  input  logic [63:0]           upd_pc_in,
  input  logic                  upd_is_cond_in,
  input  logic                  upd_taken_in,
  input  logic [63:0]           upd_target_in,
  input  logic                  upd_mispredict_in,
  input  logic                  flush_in
);

  localparam int PHT_N = 1 << PHT_IDX_BITS;
  localparam int BIW   = $clog2(BTB_ENTRIES);

  ctr_t                 pht [PHT_N];
  btb_entry_t           btb [BTB_ENTRIES];
  logic [GHR_BITS-1:0]  ghr;

  logic [LANES-1:0]     l_valid;
  logic [LANES-1:0]     l_taken;
  logic [64*LANES-1:0]  l_target;
  logic [IDW*LANES-1:0] l_id;
  logic [63:0]          l_next;
  logic [GHR_BITS-1:0]  ghr_spec;
  ckpt_t [LANES-1:0]    al_data;
  logic [CW-1:0]        al_n;

  ckpt_t                q_head;
  logic [IDW-1:0]       q_tail;
  logic [CW-1:0]        q_count;
  logic                 q_busy;
  logic                 accept;
  logic                 redirect;
  logic                 pop;
  logic [GHR_BITS-1:0]  rest_hist;
  logic [31:0]          u_idx_ghr;
  logic [PHT_IDX_BITS-1:0] u_pidx;
  logic [BIW-1:0]       u_bidx;

  assign q_busy   = (q_count != '0);
  assign redirect = upd_valid_in && upd_mispredict_in;
  assign req_ready_out = !rst_in && !flush_in && !redirect
                      && (int'(q_count) <= CKPT_DEPTH - LANES);
  assign accept   = req_valid_in && req_ready_out;
  assign pop      = upd_valid_in && upd_is_cond_in && q_busy;

  assign rest_hist = q_busy ? q_head.hist[GHR_BITS-1:0] : ghr;
  assign u_idx_ghr = q_busy ? q_head.idx_ghr : '0;
  assign u_pidx = PHT_IDX_BITS'(pht_idx(upd_pc_in, u_idx_ghr,
                                        PHT_IDX_BITS));
  assign u_bidx = BIW'(btb_idx(upd_pc_in, BIW));

  // Lane scan: predict each lane, stop after the first taken one.
  always_comb begin
    logic [63:0]             pc_i;
    logic [PHT_IDX_BITS-1:0] pi;
    logic [BIW-1:0]          bi;
    btb_entry_t              e;
    logic                    hit;
    logic                    tk;
    logic                    stop;
    int                      na;
    l_valid  = '0;
    l_taken  = '0;
    l_target = '0;
    l_id     = '0;
    al_data  = '0;
    l_next   = req_pc_in + 64'(4 * LANES);
    ghr_spec = ghr;
    stop     = 1'b0;
    na       = 0;
    for (int i = 0; i < LANES; i++) begin
      pc_i = req_pc_in + 64'(4 * i);
      pi   = PHT_IDX_BITS'(pht_idx(pc_i, 32'(ghr), PHT_IDX_BITS));
      bi   = BIW'(btb_idx(pc_i, BIW));
      e    = btb[bi];
      hit  = e.valid && (e.tag == btb_tag(pc_i, BIW, TAG_BITS));
      tk   = hit && (!e.is_cond || pht[pi][1]);
      if (!stop) begin
        l_valid[i] = 1'b1;
        l_taken[i] = tk;
        l_target[64*i +: 64] = tk ? e.target : pc_i + 64'd4;
        if (hit && e.is_cond) begin
          al_data[na].idx_ghr = 32'(ghr);
          al_data[na].hist    = 32'(ghr_spec);
          l_id[IDW*i +: IDW]  =
            IDW'((int'(q_tail) + na) % CKPT_DEPTH);
          ghr_spec = GHR_BITS'({ghr_spec, tk});
          na = na + 1;
        end
        if (tk) begin
          stop   = 1'b1;
          l_next = e.target;
        end
      end
    end
    al_n = CW'(na);
  end

  bp_ckpt_queue #(
    .DEPTH (CKPT_DEPTH),
    .LANES (LANES)
  ) u_q (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .alloc_n_in    (accept ? al_n : '0),
    .alloc_data_in (al_data),
    .pop_in        (pop),
    .clear_in      (flush_in || redirect),
    .head_out      (q_head),
    .tail_out      (q_tail),
    .count_out     (q_count)
  );

  // PHT and BTB training from resolved branches.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= CTR_INIT;
      for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '0;
    end else if (upd_valid_in) begin
      if (upd_is_cond_in)
        pht[u_pidx] <= ctr_next(pht[u_pidx], upd_taken_in);
      if (upd_taken_in) begin
        btb[u_bidx].valid   <= 1'b1;
        btb[u_bidx].tag     <= btb_tag(upd_pc_in, BIW, TAG_BITS);
        btb[u_bidx].target  <= upd_target_in;
        btb[u_bidx].is_cond <= upd_is_cond_in;
      end
    end
  end

  // Speculative GHR: flush and mispredict restore, lookups advance.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ghr <= '0;
    end else if (flush_in) begin
      if (q_busy) ghr <= q_head.hist[GHR_BITS-1:0];
    end else if (redirect) begin
      if (upd_is_cond_in) ghr <= GHR_BITS'({rest_hist, upd_taken_in});
    end else if (accept) begin
      ghr <= ghr_spec;
    end
  end

  // Registered response, one cycle after an accepted request.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      resp_valid_out  <= 1'b0;
      resp_lane_valid <= '0;
      resp_taken      <= '0;
      resp_target     <= '0;
      resp_next_pc    <= '0;
      resp_ckpt_id    <= '0;
    end else begin
      resp_valid_out <= accept;
      if (accept) begin
        resp_lane_valid <= l_valid;
        resp_taken      <= l_taken;
        resp_target     <= l_target;
        resp_next_pc    <= l_next;
        resp_ckpt_id    <= l_id;
      end
    end
  end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor (LANES=2, CKPT_DEPTH=4).
module tb_gshare_btb_predictor;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         req_valid_in;
  logic [63:0]  req_pc_in;
  logic         req_ready_out;
  logic         resp_valid_out;
  logic [1:0]   resp_lane_valid;
  logic [1:0]   resp_taken;
  logic [127:0] resp_target;
  logic [63:0]  resp_next_pc;
  logic [3:0]   resp_ckpt_id;
  logic         upd_valid_in;
  logic [63:0]  upd_pc_in;
  logic         upd_is_cond_in;
  logic         upd_taken_in;
  logic [63:0]  upd_target_in;
  logic         upd_mispredict_in;
  logic         flush_in;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  gshare_btb_predictor #(
    .LANES      (2),
    .CKPT_DEPTH (4)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .req_valid_in      (req_valid_in),
    .req_pc_in         (req_pc_in),
    .req_ready_out     (req_ready_out),
    .resp_valid_out    (resp_valid_out),
    .resp_lane_valid   (resp_lane_valid),
    .resp_taken        (resp_taken),
    .resp_target       (resp_target),
    .resp_next_pc      (resp_next_pc),
    .resp_ckpt_id      (resp_ckpt_id),
    .upd_valid_in      (upd_valid_in),
    .upd_pc_in         (upd_pc_in),
    .upd_is_cond_in    (upd_is_cond_in),
    .upd_taken_in      (upd_taken_in),
    .upd_target_in     (upd_target_in),
    .upd_mispredict_in (upd_mispredict_in),
    .flush_in          (flush_in)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    req_valid_in      = 1'b0;
    req_pc_in         = '0;
    upd_valid_in      = 1'b0;
    upd_pc_in         = '0;
    upd_is_cond_in    = 1'b0;
    upd_taken_in      = 1'b0;
    upd_target_in     = '0;
    upd_mispredict_in = 1'b0;
    flush_in          = 1'b0;
  endtask

  task automatic upd(input logic [63:0] pc, input logic cond,
                     input logic tk, input logic [63:0] tgt,
                     input logic mp);
    upd_valid_in      = 1'b1;
    upd_pc_in         = pc;
    upd_is_cond_in    = cond;
    upd_taken_in      = tk;
    upd_target_in     = tgt;
    upd_mispredict_in = mp;
    step();
    upd_valid_in      = 1'b0;
    upd_mispredict_in = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_in = 1'b1;
    step();
    step();
    checks++;
    if (resp_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b exp 0", resp_valid_out);
    end
    checks++;
    if (resp_lane_valid !== 2'b00 || resp_next_pc !== 64'd0) begin
      errors++;
      $display("FAIL reset_outs got %b %h exp 0",
               resp_lane_valid, resp_next_pc);
    end
    checks++;
    if (dut.ghr !== 8'd0 || dut.u_q.count !== 3'd0) begin
      errors++;
      $display("FAIL reset_state ghr %h cnt %0d exp 0 0",
               dut.ghr, dut.u_q.count);
    end
    checks++;
    if (dut.pht[0] !== 2'b01 || dut.pht[1023] !== 2'b01) begin
      errors++;
      $display("FAIL reset_pht got %b %b exp 01",
               dut.pht[0], dut.pht[1023]);
    end
    checks++;
    if (dut.btb[5].valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_btb got %b exp 0", dut.btb[5].valid);
    end
    rst_in = 1'b0;
    #1;
    checks++;
    if (req_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", req_ready_out);
    end
  endtask

  task automatic test_lookup_basic();
    req_valid_in = 1'b1;
    req_pc_in    = 64'h1000;
    step();
    req_valid_in = 1'b0;
    checks++;
    if (resp_valid_out !== 1'b1 || resp_lane_valid !== 2'b11 ||
        resp_taken !== 2'b00) begin
      errors++;
      $display("FAIL basic_lanes got v%b l%b t%b exp v1 l11 t00",
               resp_valid_out, resp_lane_valid, resp_taken);
    end
    checks++;
    if (resp_next_pc !== 64'h1008 ||
        resp_target !== {64'h1008, 64'h1004}) begin
      errors++;
      $display("FAIL basic_pc got %h %h exp 1008",
               resp_next_pc, resp_target);
    end
    checks++;
    if (dut.ghr !== 8'd0) begin
      errors++;
      $display("FAIL basic_ghr got %h exp 00", dut.ghr);
    end
    step();
    checks++;
    if (resp_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_drop got %b exp 0", resp_valid_out);
    end
  endtask

  task automatic test_train_taken();
    upd(64'h2000, 1'b1, 1'b1, 64'h3000, 1'b0);
    checks++;
    if (dut.pht[0] !== 2'b10) begin
      errors++;
      $display("FAIL train_ctr1 got %b exp 10", dut.pht[0]);
    end
    upd(64'h2000, 1'b1, 1'b1, 64'h3000, 1'b0);
    checks++;
    if (dut.pht[0] !== 2'b11) begin
      errors++;
      $display("FAIL train_ctr2 got %b exp 11", dut.pht[0]);
    end
    req_valid_in = 1'b1;
    req_pc_in    = 64'h2000;
    step();
    req_valid_in = 1'b0;
    checks++;
    if (resp_lane_valid !== 2'b01 || resp_taken !== 2'b01) begin
      errors++;
      $display("FAIL train_lanes got l%b t%b exp l01 t01",
               resp_lane_valid, resp_taken);
    end
    checks++;
    if (resp_next_pc !== 64'h3000 ||
        resp_target[63:0] !== 64'h3000) begin
      errors++;
      $display("FAIL train_target got %h %h exp 3000",
               resp_next_pc, resp_target[63:0]);
    end
    checks++;
    if (resp_ckpt_id[1:0] !== 2'd0 || dut.u_q.count !== 3'd1 ||
        dut.ghr !== 8'h01) begin
      errors++;
      $display("FAIL train_ckpt got id%0d cnt%0d ghr%h exp 0 1 01",
               resp_ckpt_id[1:0], dut.u_q.count, dut.ghr);
    end
  endtask

  task automatic test_mispredict();
    upd_valid_in      = 1'b1;
    upd_pc_in         = 64'h2000;
    upd_is_cond_in    = 1'b1;
    upd_taken_in      = 1'b0;
    upd_mispredict_in = 1'b1;
    req_valid_in      = 1'b1;
    req_pc_in         = 64'h1000;
    #1;
    checks++;
    if (req_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL misp_ready got %b exp 0", req_ready_out);
    end
    step();
    idle();
    checks++;
    if (dut.ghr !== 8'h00 || dut.u_q.count !== 3'd0) begin
      errors++;
      $display("FAIL misp_state got ghr%h cnt%0d exp 00 0",
               dut.ghr, dut.u_q.count);
    end
    checks++;
    if (dut.pht[0] !== 2'b10 || resp_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL misp_ctr got %b v%b exp 10 v0",
               dut.pht[0], resp_valid_out);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++)
      upd(64'h100, 1'b1, 1'b0, 64'h0, 1'b0);
    checks++;
    if (dut.pht[10'h40] !== 2'b00 || dut.btb[7'h40].valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_low got %b v%b exp 00 v0",
               dut.pht[10'h40], dut.btb[7'h40].valid);
    end
    for (int i = 0; i < 5; i++)
      upd(64'h100, 1'b1, 1'b1, 64'h900, 1'b0);
    checks++;
    if (dut.pht[10'h40] !== 2'b11) begin
      errors++;
      $display("FAIL sat_high got %b exp 11", dut.pht[10'h40]);
    end
    checks++;
    if (dut.btb[7'h40].valid !== 1'b1 ||
        dut.btb[7'h40].target !== 64'h900) begin
      errors++;
      $display("FAIL sat_btb got v%b %h exp v1 900",
               dut.btb[7'h40].valid, dut.btb[7'h40].target);
    end
  endtask

  task automatic test_queue_full();
    upd(64'h4400, 1'b1, 1'b1, 64'h7000, 1'b0);
    upd(64'h4400, 1'b1, 1'b0, 64'h0, 1'b0);
    upd(64'h4404, 1'b1, 1'b1, 64'h7100, 1'b0);
    upd(64'h4404, 1'b1, 1'b0, 64'h0, 1'b0);
    req_valid_in = 1'b1;
    req_pc_in    = 64'h4400;
    step();
    checks++;
    if (resp_lane_valid !== 2'b11 || resp_taken !== 2'b00 ||
        resp_next_pc !== 64'h4408 || resp_ckpt_id !== 4'b0100) begin
      errors++;
      $display("FAIL qf_g1 got l%b t%b %h id%b exp l11 t00 4408 0100",
               resp_lane_valid, resp_taken, resp_next_pc, resp_ckpt_id);
    end
    checks++;
    if (req_ready_out !== 1'b1 || dut.u_q.count !== 3'd2) begin
      errors++;
      $display("FAIL qf_g1_ready got r%b cnt%0d exp r1 2",
               req_ready_out, dut.u_q.count);
    end
    step();
    req_valid_in = 1'b0;
    #1;
    checks++;
    if (resp_ckpt_id !== 4'b1110 || req_ready_out !== 1'b0 ||
        dut.u_q.count !== 3'd4) begin
      errors++;
      $display("FAIL qf_full got id%b r%b cnt%0d exp 1110 r0 4",
               resp_ckpt_id, req_ready_out, dut.u_q.count);
    end
    upd(64'h4400, 1'b1, 1'b0, 64'h0, 1'b0);
    #1;
    checks++;
    if (req_ready_out !== 1'b0 || dut.u_q.count !== 3'd3 ||
        dut.pht[10'h100] !== 2'b00) begin
      errors++;
      $display("FAIL qf_pop1 got r%b cnt%0d ctr%b exp r0 3 00",
               req_ready_out, dut.u_q.count, dut.pht[10'h100]);
    end
    upd(64'h4404, 1'b1, 1'b0, 64'h0, 1'b0);
    #1;
    checks++;
    if (req_ready_out !== 1'b1 || dut.u_q.count !== 3'd2 ||
        dut.pht[10'h101] !== 2'b00) begin
      errors++;
      $display("FAIL qf_pop2 got r%b cnt%0d ctr%b exp r1 2 00",
               req_ready_out, dut.u_q.count, dut.pht[10'h101]);
    end
    req_valid_in = 1'b1;
    req_pc_in    = 64'h4400;
    step();
    req_valid_in = 1'b0;
    checks++;
    if (resp_ckpt_id !== 4'b0100 || dut.u_q.tail !== 2'd2 ||
        dut.u_q.count !== 3'd4) begin
      errors++;
      $display("FAIL qf_wrap got id%b tail%0d cnt%0d exp 0100 2 4",
               resp_ckpt_id, dut.u_q.tail, dut.u_q.count);
    end
  endtask

  task automatic test_flush();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    checks++;
    if (dut.u_q.count !== 3'd0 || dut.ghr !== 8'h00) begin
      errors++;
      $display("FAIL fl_clear got cnt%0d ghr%h exp 0 00",
               dut.u_q.count, dut.ghr);
    end
    upd(64'h5008, 1'b1, 1'b1, 64'h6000, 1'b0);
    req_valid_in = 1'b1;
    req_pc_in    = 64'h5008;
    step();
    checks++;
    if (resp_taken !== 2'b01 || resp_next_pc !== 64'h6000 ||
        resp_ckpt_id[1:0] !== 2'd0 || dut.ghr !== 8'h01) begin
      errors++;
      $display("FAIL fl_a got t%b %h id%0d ghr%h exp 01 6000 0 01",
               resp_taken, resp_next_pc, resp_ckpt_id[1:0], dut.ghr);
    end
    step();
    checks++;
    if (resp_lane_valid !== 2'b11 || resp_taken !== 2'b00 ||
        resp_next_pc !== 64'h5010 || resp_ckpt_id[1:0] !== 2'd1 ||
        dut.ghr !== 8'h02) begin
      errors++;
      $display("FAIL fl_b got l%b t%b %h id%0d ghr%h exp 11 00 5010 1 02",
               resp_lane_valid, resp_taken, resp_next_pc,
               resp_ckpt_id[1:0], dut.ghr);
    end
    step();
    req_valid_in = 1'b0;
    checks++;
    if (resp_taken !== 2'b01 || resp_ckpt_id[1:0] !== 2'd2 ||
        dut.ghr !== 8'h05 || dut.u_q.count !== 3'd3) begin
      errors++;
      $display("FAIL fl_c got t%b id%0d ghr%h cnt%0d exp 01 2 05 3",
               resp_taken, resp_ckpt_id[1:0], dut.ghr, dut.u_q.count);
    end
    upd(64'h5008, 1'b1, 1'b1, 64'h6000, 1'b0);
    checks++;
    if (dut.pht[2] !== 2'b11 || dut.u_q.count !== 3'd2) begin
      errors++;
      $display("FAIL fl_res_a got ctr%b cnt%0d exp 11 2",
               dut.pht[2], dut.u_q.count);
    end
    flush_in       = 1'b1;
    upd_valid_in   = 1'b1;
    upd_pc_in      = 64'h5008;
    upd_is_cond_in = 1'b1;
    upd_taken_in   = 1'b0;
    req_valid_in   = 1'b1;
    req_pc_in      = 64'h1000;
    #1;
    checks++;
    if (req_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL fl_ready got %b exp 0", req_ready_out);
    end
    step();
    idle();
    checks++;
    if (dut.ghr !== 8'h01 || dut.u_q.count !== 3'd0 ||
        resp_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL fl_state got ghr%h cnt%0d v%b exp 01 0 0",
               dut.ghr, dut.u_q.count, resp_valid_out);
    end
    checks++;
    if (dut.pht[3] !== 2'b00) begin
      errors++;
      $display("FAIL fl_train got %b exp 00", dut.pht[3]);
    end
  endtask

  task automatic test_reset_mid();
    req_valid_in = 1'b1;
    req_pc_in    = 64'h5008;
    step();
    checks++;
    if (dut.u_q.count !== 3'd1) begin
      errors++;
      $display("FAIL rm_pre got cnt%0d exp 1", dut.u_q.count);
    end
    req_pc_in = 64'h1000;
    rst_in    = 1'b1;
    step();
    rst_in       = 1'b0;
    req_valid_in = 1'b0;
    checks++;
    if (resp_valid_out !== 1'b0 || dut.u_q.count !== 3'd0 ||
        dut.ghr !== 8'h00) begin
      errors++;
      $display("FAIL rm_state got v%b cnt%0d ghr%h exp 0 0 00",
               resp_valid_out, dut.u_q.count, dut.ghr);
    end
    checks++;
    if (dut.pht[2] !== 2'b01 || dut.btb[2].valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_arrays got ctr%b v%b exp 01 0",
               dut.pht[2], dut.btb[2].valid);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    idle();
    test_reset();
    test_lookup_basic();
    test_train_taken();
    test_mispredict();
    test_saturation();
    test_queue_full();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
